pipelined_csel_adder: RTL and testbench

//   Parametrised, pipelined carry-select adder/subtractor.
//   - Operands are split into BLOCK-bit blocks. Each block precomputes sums for carry-in 0 and 1, then selects one.
//   - One block is resolved per pipeline stage; the carry between blocks is registered.
//   - A valid/ready handshake with full backpressure sits on the input and the output.
//   - Throughput is one operation per cycle. It is the datapath adder for wider ALU and accumulator paths.
//

---
 rtl/pipelined_csel_adder.sv | 183 ++++++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// ---------------------------------------------------------------------------
// pipelined_csel_adder
//
// Purpose:
//   Parametrised, pipelined carry-select adder/subtractor. The operands are
//   cut into NBLK = WIDTH/BLOCK blocks and one block is resolved per stage.
//   Each stage precomputes its block sum for carry-in 0 and carry-in 1 and
//   then selects one with the carry registered by the previous stage. The
//   adder sustains one operation per cycle.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a, b, cin, sub are valid this cycle
//   in_ready   out  1      stage 0 can accept (transfer on in_valid & in_ready)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in, used only when sub = 0
//   sub        in   1      0: a + b + cin    1: a - b (a + ~b + 1)
//   out_valid  out  1      sum, cout, ovf are valid
//   out_ready  in   1      consumer accepts (transfer on out_valid & out_ready)
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry out of the MSB (for sub, 1 = no borrow)
//   ovf        out  1      signed overflow (carry into MSB ^ carry out of MSB)
//
// Handshake (both sides): a word transfers on a rising clock edge where
// valid and ready are both 1. The producer holds its word while waiting;
// stage k advances when it is empty or the stage after it advances, so the
// ready chain runs combinationally from out_ready back to in_ready. While
// out_valid=1 and out_ready=0 nothing in a full pipeline moves.
// ---------------------------------------------------------------------------
module pipelined_csel_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Guarded so an illegal configuration still elaborates far enough to
    // report the $error below instead of failing on a divide by zero.
    localparam int NBLK = (BLOCK >= 1 && WIDTH >= BLOCK) ? WIDTH / BLOCK : 1;

    generate
        if (BLOCK < 1) begin : g_bad_block
            $error("pipelined_csel_adder: BLOCK must be >= 1");
        end else if (WIDTH < BLOCK) begin : g_bad_width
            $error("pipelined_csel_adder: WIDTH must be >= BLOCK");
        end else if (WIDTH % BLOCK != 0) begin : g_bad_mod
            $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Stage registers. s_q[k] holds the bits resolved so far (blocks 0..k);
    // a_q/b_q carry the operands forward (b already inverted for sub), and
    // only their unresolved upper blocks plus the MSB are consumed later.
    // -----------------------------------------------------------------------
    logic [NBLK-1:0]  v_q;
    logic [NBLK-1:0]  c_q;
    logic [WIDTH-1:0] s_q [NBLK];
    logic [WIDTH-1:0] a_q [NBLK];
    logic [WIDTH-1:0] b_q [NBLK];
    logic             ovf_q;

    // Per-stage inputs (what stage k would load) and next values.
    logic [NBLK-1:0]  op_v;
    logic [NBLK-1:0]  op_c;
    logic [WIDTH-1:0] op_a [NBLK];
    logic [WIDTH-1:0] op_b [NBLK];
    logic [WIDTH-1:0] part_s [NBLK];
    logic [WIDTH-1:0] nxt_s [NBLK];
    logic [NBLK-1:0]  nxt_c;
    logic             nxt_ovf;

    // rdy[k] = stage k may load this cycle; rdy[NBLK] is the consumer.
    logic [NBLK:0]    rdy;

    assign rdy[NBLK] = out_ready;

    genvar k;
    generate
        for (k = 0; k < NBLK; k++) begin : g_stage
            localparam int LSB = k * BLOCK;
            localparam logic [WIDTH-1:0] MASK = WIDTH'({BLOCK{1'b1}}) << LSB;

            logic [BLOCK:0] sum_c0;
            logic [BLOCK:0] sum_c1;
            logic [BLOCK:0] pick;

            assign rdy[k] = ~v_q[k] | rdy[k+1];

            if (k == 0) begin : g_head
                // Subtraction is a + ~b + 1: invert b here and force the
                // carry-in so every later stage is a plain adder.
                assign op_v[0]   = in_valid;
                assign op_a[0]   = a;
                assign op_b[0]   = sub ? ~b : b;
                assign op_c[0]   = sub | cin;
                assign part_s[0] = '0;
            end else begin : g_body
                assign op_v[k]   = v_q[k-1];
                assign op_a[k]   = a_q[k-1];
                assign op_b[k]   = b_q[k-1];
                assign op_c[k]   = c_q[k-1];
                assign part_s[k] = s_q[k-1];
            end

            // Both candidate block sums are formed independently of the
            // incoming carry; the carry only drives the final select.
            assign sum_c0 = {1'b0, op_a[k][LSB +: BLOCK]}
                          + {1'b0, op_b[k][LSB +: BLOCK]};
            assign sum_c1 = {1'b0, op_a[k][LSB +: BLOCK]}
                          + {1'b0, op_b[k][LSB +: BLOCK]}
                          + {{BLOCK{1'b0}}, 1'b1};
            assign pick   = op_c[k] ? sum_c1 : sum_c0;

            assign nxt_s[k] = (part_s[k] & ~MASK)
                            | (WIDTH'(pick[BLOCK-1:0]) << LSB);
            assign nxt_c[k] = pick[BLOCK];

            if (k == NBLK - 1) begin : g_tail
                // Carry into the MSB recovered from the MSB's sum bit:
                // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
                logic msb_carry_in;
                assign msb_carry_in = op_a[k][WIDTH-1] ^ op_b[k][WIDTH-1]
                                    ^ nxt_s[k][WIDTH-1];
                assign nxt_ovf      = msb_carry_in ^ nxt_c[k];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Pipeline registers. A stage copies its upstream valid whenever it may
    // advance; data is only loaded for a valid word so that bubbles leave
    // the previous contents untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < NBLK; i++) begin
                s_q[i] <= '0;
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBLK; i++) begin
                if (rdy[i]) begin
                    v_q[i] <= op_v[i];
                    if (op_v[i]) begin
                        s_q[i] <= nxt_s[i];
                        c_q[i] <= nxt_c[i];
                        a_q[i] <= op_a[i];
                        b_q[i] <= op_b[i];
                    end
                end
            end
            if (rdy[NBLK-1] && op_v[NBLK-1]) begin
                ovf_q <= nxt_ovf;
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NBLK-1];
    assign sum       = s_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: an 8-bit/4-bit-block instance for the
// directed vectors and corner sequences, and a 32-bit/8-bit-block instance
// for the random streaming run against a reference model.
module tb_pipelined_csel_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic       n_in_valid, n_in_ready, n_cin, n_sub;
    logic       n_out_valid, n_out_ready, n_cout, n_ovf;
    logic [7:0] n_a, n_b, n_sum;

    pipelined_csel_adder #(.WIDTH(8), .BLOCK(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .sum(n_sum), .cout(n_cout), .ovf(n_ovf)
    );

    // ---------------- 32-bit instance ----------------
    logic        w_in_valid, w_in_ready, w_cin, w_sub;
    logic        w_out_valid, w_out_ready, w_cout, w_ovf;
    logic [31:0] w_a, w_b, w_sum;

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [9:0]  exp_q [$];   // {ovf, cout, sum} for the 8-bit instance
    logic [33:0] wexp_q [$];  // {ovf, cout, sum} for the 32-bit instance

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Independent reference: full-width add plus a separate add of the low
    // WIDTH-1 bits to find the carry into the MSB.
    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [31:0] bp;
        logic        c;
        logic [32:0] full;
        logic [31:0] low;
        bp   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bp} + 33'(c);
        low  = {1'b0, a[30:0]} + {1'b0, bp[30:0]} + 32'(c);
        return {low[31] ^ full[32], full[32], full[31:0]};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [11];
    vec_t bp_ops [5];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int sent, got, first_cyc, last_cyc, seen;
        int nacc, nrecv;
        logic pending;
        logic [33:0] wexp;
        logic [9:0]  nexp;

        //            a      b      cin   sub   sum    co    ov
        vecs[0]  = '{8'h05, 8'h06, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0};
        vecs[1]  = '{8'hFE, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{8'h0A, 8'h02, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0};
        vecs[4]  = '{8'h02, 8'h0A, 1'b0, 1'b1, 8'hF8, 1'b0, 1'b0};
        vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[10] = '{8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};

        bp_ops[0] = '{8'h0A, 8'h02, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0};
        bp_ops[1] = '{8'h05, 8'h06, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0};
        bp_ops[2] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        bp_ops[3] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
        bp_ops[4] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        n_in_valid = 0; n_a = 0; n_b = 0; n_cin = 0; n_sub = 0; n_out_ready = 1;
        w_in_valid = 0; w_a = 0; w_b = 0; w_cin = 0; w_sub = 0; w_out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset out_valid8", n_out_valid, 0);
        check("reset result8", {n_ovf, n_cout, n_sum}, 0);
        check("reset in_ready8", n_in_ready, 1);
        check("reset out_valid32", w_out_valid, 0);
        check("reset result32", {w_ovf, w_cout, w_sum}, 0);
        check("reset in_ready32", w_in_ready, 1);

        // ---------------- directed vectors, one at a time ----------------
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_a = vecs[i].a; n_b = vecs[i].b; n_cin = vecs[i].cin; n_sub = vecs[i].sub;
            n_in_valid = 1; n_out_ready = 1;
            #1;
            check($sformatf("v%0d in_ready", i), n_in_ready, 1);
            lat = 0;
            do begin
                @(negedge clk);
                // Scramble operands while idle: they must not be sampled.
                n_in_valid = 0;
                n_a = 8'($urandom_range(0, 255)); n_b = 8'($urandom_range(0, 255));
                n_cin = 1'($urandom_range(0, 1)); n_sub = 1'($urandom_range(0, 1));
                #1;
                lat++;
            end while (!n_out_valid && lat < 8);
            check($sformatf("v%0d latency", i), lat, 2);
            check($sformatf("v%0d sum", i), n_sum, vecs[i].s);
            check($sformatf("v%0d cout", i), n_cout, vecs[i].co);
            check($sformatf("v%0d ovf", i), n_ovf, vecs[i].ov);
            @(negedge clk);
            #1;
            check($sformatf("v%0d bubble", i), n_out_valid, 0);
        end

        // ---------------- backpressure: 5 ops, 4-cycle stall ----------------
        exp_q.delete();
        sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            n_out_ready = (cyc >= 6);
            if (sent < 5) begin
                n_a = bp_ops[sent].a; n_b = bp_ops[sent].b;
                n_cin = bp_ops[sent].cin; n_sub = bp_ops[sent].sub;
                n_in_valid = 1;
            end else begin
                n_in_valid = 0;
            end
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                check($sformatf("bp c%0d in_ready", cyc), n_in_ready, 0);
                check($sformatf("bp c%0d out_valid", cyc), n_out_valid, 1);
                if (exp_q.size() > 0)
                    check($sformatf("bp c%0d stalled result", cyc), {n_ovf, n_cout, n_sum}, exp_q[0]);
                else
                    check($sformatf("bp c%0d queue", cyc), 0, 1);
            end
            if (cyc == 5) check("bp held count", sent, 2);
            if (n_in_valid && n_in_ready) begin
                exp_q.push_back({bp_ops[sent].ov, bp_ops[sent].co, bp_ops[sent].s});
                sent++;
            end
            if (n_out_valid && n_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp unexpected output", 1, 0);
                end else begin
                    nexp = exp_q.pop_front();
                    check($sformatf("bp result %0d", got), {n_ovf, n_cout, n_sum}, nexp);
                end
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
        end
        check("bp results drained", got, 5);
        check("bp first emit cycle", first_cyc, 6);
        check("bp drain without bubbles", last_cyc - first_cyc, 4);

        // ---------------- reset mid-flight ----------------
        @(negedge clk);
        n_out_ready = 0;
        n_a = 8'h33; n_b = 8'h11; n_cin = 0; n_sub = 0; n_in_valid = 1;
        @(negedge clk);
        n_a = 8'h01; n_b = 8'h02;
        @(negedge clk);
        n_in_valid = 0;
        #1;
        check("rst pre out_valid", n_out_valid, 1);
        check("rst pre sum", n_sum, 8'h44);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst async out_valid", n_out_valid, 0);
        check("rst async result", {n_ovf, n_cout, n_sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_out_ready = 1;
        #1;
        check("rst release in_ready", n_in_ready, 1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (n_out_valid) seen++;
        end
        check("rst no stale results", seen, 0);

        // ---------------- 32-bit latency ----------------
        @(negedge clk);
        w_a = 32'hFFFF_FFFF; w_b = 32'h0000_0001; w_cin = 0; w_sub = 0;
        w_in_valid = 1; w_out_ready = 1;
        lat = 0;
        do begin
            @(negedge clk);
            w_in_valid = 0;
            #1;
            lat++;
        end while (!w_out_valid && lat < 10);
        check("w latency", lat, 4);
        check("w wrap result", {w_ovf, w_cout, w_sum}, {1'b0, 1'b1, 32'h0});

        // ---------------- 32-bit random stream ----------------
        wexp_q.delete();
        nacc = 0; nrecv = 0; pending = 0;
        for (int cyc = 0; cyc < 20000 && nrecv < 1000; cyc++) begin
            @(negedge clk);
            if (!pending && nacc < 1000) begin
                w_a = $urandom(); w_b = $urandom();
                w_cin = 1'($urandom_range(0, 1)); w_sub = 1'($urandom_range(0, 1));
                pending = 1;
            end
            w_in_valid  = pending && ($urandom_range(0, 3) != 0);
            w_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (w_out_valid && !w_out_ready && wexp_q.size() > 0)
                check("w stalled result", {w_ovf, w_cout, w_sum}, wexp_q[0]);
            if (w_in_valid && w_in_ready) begin
                wexp_q.push_back(model32(w_a, w_b, w_cin, w_sub));
                pending = 0;
                nacc++;
            end
            if (w_out_valid && w_out_ready) begin
                if (wexp_q.size() == 0) begin
                    check("w unexpected output", 1, 0);
                end else begin
                    wexp = wexp_q.pop_front();
                    check($sformatf("w result %0d", nrecv), {w_ovf, w_cout, w_sum}, wexp);
                end
                nrecv++;
            end
        end
        w_in_valid = 0;
        check("w results received", nrecv, 1000);
        check("w queue empty", wexp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
